// File: rtl/scpad_pkg.sv
// Shared scratchpad types: crossbar descriptor, SRAM write request and default beat/row widths.
package scpad_pkg;
  localparam int SCPAD_BEAT_BITS = 64;
  localparam int SCPAD_ROW_BITS  = 512;

  typedef struct packed {
    logic [7:0] slot_mask;
    logic [7:0] shift;
    logic [7:0] valid_mask;
  } xbar_desc_t;

  typedef struct packed {
    logic                      valid;
    logic [SCPAD_ROW_BITS-1:0] wdata;
    xbar_desc_t                xbar;
  } sram_write_req_t;
endpackage

// File: rtl/scpad_slot_fifo.sv
// Completion-order FIFO of slot indices: up to two pushes (a before b) and one pop per cycle.
module scpad_slot_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_a,
  input  logic [$clog2(DEPTH)-1:0] push_a_idx,
  input  logic                     push_b,
  input  logic [$clog2(DEPTH)-1:0] push_b_idx,
  input  logic                     pop,
  output logic                     empty,
  output logic [$clog2(DEPTH)-1:0] head
);
  localparam int IW = $clog2(DEPTH);

  logic [IW-1:0] mem [DEPTH];
  logic [IW-1:0] rd_ptr, wr_ptr;
  logic [IW:0]   count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_a) mem[wr_ptr] <= push_a_idx;
      if (push_b) mem[wr_ptr + IW'(push_a)] <= push_b_idx;
      wr_ptr <= wr_ptr + IW'(push_a) + IW'(push_b);
      if (pop) rd_ptr <= rd_ptr + IW'(1);
      count <= count + (IW+1)'(push_a) + (IW+1)'(push_b) - (IW+1)'(pop);
    end
  end

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
endmodule

// File: rtl/sram_write_assembler.sv
// Gathers interleaved DRAM beats per transaction ID into full scratchpad rows, emitted in completion order.
// Optional sticky protocol error flag enabled by SRAM_WRITE_ASSEMBLER_ERR_EN.
module sram_write_assembler
  import scpad_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int ID_W      = 8,
  parameter int BEAT_BITS = SCPAD_BEAT_BITS,
  parameter int ROW_BITS  = SCPAD_ROW_BITS,
  localparam int BEATS_MAX = ROW_BITS / BEAT_BITS,
  localparam int NBW       = $clog2(BEATS_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [ID_W-1:0]      alloc_id,
  input  xbar_desc_t           alloc_xbar,
  input  logic [NBW-1:0]       alloc_num_beats,
  input  logic                 beat_valid,
  input  logic [ID_W-1:0]      beat_id,
  input  logic [BEAT_BITS-1:0] beat_data,
  output sram_write_req_t      sram_write_req,
  input  logic                 be_stall,
  output logic                 sram_write_req_latched,
  output logic                 busy,
  output logic                 err
);
  localparam int SW = $clog2(NUM_SLOTS);

  logic [NUM_SLOTS-1:0] slot_busy;
  logic [ID_W-1:0]      slot_id   [NUM_SLOTS];
  xbar_desc_t           slot_xbar [NUM_SLOTS];
  logic [NBW-1:0]       slot_exp  [NUM_SLOTS];
  logic [NBW-1:0]       slot_cnt  [NUM_SLOTS];
  logic [ROW_BITS-1:0]  slot_data [NUM_SLOTS];

  logic                free_found, dup, match_found, beat_done;
  logic [SW-1:0]       free_idx, match_idx, fifo_head;
  logic [NBW-1:0]      alloc_exp;
  logic [ROW_BITS-1:0] beat_row;
  logic                alloc_fire, zero_alloc, handoff, load_en;
  logic                load_fifo, load_beat, load_zero, push_a, push_b, fifo_empty;
  sram_write_req_t     out_q;

  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    dup         = 1'b0;
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_busy[i] && slot_id[i] == alloc_id) dup = 1'b1;
      if (beat_valid && slot_busy[i] && slot_cnt[i] != slot_exp[i] && slot_id[i] == beat_id) begin
        match_found = 1'b1;
        match_idx   = SW'(i);
      end
    end
  end

  always_comb begin
    beat_row = slot_data[match_idx];
    if (match_found) beat_row[int'(slot_cnt[match_idx]) * BEAT_BITS +: BEAT_BITS] = beat_data;
  end

  assign alloc_exp   = (alloc_num_beats > NBW'(BEATS_MAX)) ? NBW'(BEATS_MAX) : alloc_num_beats;
  assign alloc_ready = free_found && !dup;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign zero_alloc  = alloc_fire && (alloc_num_beats == '0);
  assign beat_done   = match_found && ((slot_cnt[match_idx] + NBW'(1)) == slot_exp[match_idx]);

  // With an empty FIFO a fresh completion bypasses it straight into the output register,
  // giving one-cycle latency; the beat completion outranks a same-cycle zero-beat allocation.
  assign handoff   = out_q.valid && !be_stall;
  assign load_en   = !out_q.valid || handoff;
  assign load_fifo = load_en && !fifo_empty;
  assign load_beat = load_en && fifo_empty && beat_done;
  assign load_zero = load_en && fifo_empty && !beat_done && zero_alloc;
  assign push_a    = beat_done && !load_beat;
  assign push_b    = zero_alloc && !load_zero;

  scpad_slot_fifo #(.DEPTH(NUM_SLOTS)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_a     (push_a),
    .push_a_idx (match_idx),
    .push_b     (push_b),
    .push_b_idx (free_idx),
    .pop        (load_fifo),
    .empty      (fifo_empty),
    .head       (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_busy <= '0;
      out_q     <= '0;
    end else begin
      if (match_found) begin
        slot_data[match_idx] <= beat_row;
        slot_cnt[match_idx]  <= slot_cnt[match_idx] + NBW'(1);
      end
      if (alloc_fire && !load_zero) begin
        slot_busy[free_idx] <= 1'b1;
        slot_id[free_idx]   <= alloc_id;
        slot_xbar[free_idx] <= alloc_xbar;
        slot_exp[free_idx]  <= alloc_exp;
        slot_cnt[free_idx]  <= '0;
        slot_data[free_idx] <= '0;
      end
      if (load_fifo) slot_busy[fifo_head] <= 1'b0;
      if (load_beat) slot_busy[match_idx] <= 1'b0;

      if (load_fifo) begin
        out_q.valid <= 1'b1;
        out_q.wdata <= slot_data[fifo_head];
        out_q.xbar  <= slot_xbar[fifo_head];
      end else if (load_beat) begin
        out_q.valid <= 1'b1;
        out_q.wdata <= beat_row;
        out_q.xbar  <= slot_xbar[match_idx];
      end else if (load_zero) begin
        out_q.valid <= 1'b1;
        out_q.wdata <= '0;
        out_q.xbar  <= alloc_xbar;
      end else if (handoff) begin
        out_q <= '0;
      end
    end
  end

  assign sram_write_req         = out_q;
  assign sram_write_req_latched = handoff;
  assign busy                   = (|slot_busy) || out_q.valid;

`ifdef SRAM_WRITE_ASSEMBLER_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if ((beat_valid && !match_found) ||
             (alloc_valid && (dup || alloc_num_beats > NBW'(BEATS_MAX)))) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_sram_write_assembler.sv
// Directed bench for sram_write_assembler: expected rows are queued at stimulus time and a monitor
// compares them against every handoff; timing and flag checks are made inline.
module tb_sram_write_assembler;
  import scpad_pkg::*;

  localparam int ROW_BITS  = 512;
  localparam int BEAT_BITS = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            alloc_valid = 1'b0;
  logic            alloc_ready;
  logic [7:0]      alloc_id = '0;
  xbar_desc_t      alloc_xbar = '0;
  logic [3:0]      alloc_num_beats = '0;
  logic            beat_valid = 1'b0;
  logic [7:0]      beat_id = '0;
  logic [63:0]     beat_data = '0;
  sram_write_req_t sram_write_req;
  logic            be_stall = 1'b0;
  logic            sram_write_req_latched;
  logic            busy;
  logic            err;

  sram_write_assembler dut (
    .clk                    (clk),
    .rst                    (rst),
    .alloc_valid            (alloc_valid),
    .alloc_ready            (alloc_ready),
    .alloc_id               (alloc_id),
    .alloc_xbar             (alloc_xbar),
    .alloc_num_beats        (alloc_num_beats),
    .beat_valid             (beat_valid),
    .beat_id                (beat_id),
    .beat_data              (beat_data),
    .sram_write_req         (sram_write_req),
    .be_stall               (be_stall),
    .sram_write_req_latched (sram_write_req_latched),
    .busy                   (busy),
    .err                    (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int handoffs = 0;
  logic [ROW_BITS-1:0] exp_data_q [$];
  xbar_desc_t          exp_xbar_q [$];

  task automatic chk(input string name, input logic [ROW_BITS-1:0] act, input logic [ROW_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [ROW_BITS-1:0] ed;
    xbar_desc_t          ex;
    forever begin
      @(negedge clk);
      if (!rst && sram_write_req.valid && !be_stall) begin
        handoffs++;
        checks++;
        if (exp_data_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req: got wdata %0h xbar %0h with nothing expected",
                   sram_write_req.wdata, sram_write_req.xbar);
        end else begin
          ed = exp_data_q.pop_front();
          ex = exp_xbar_q.pop_front();
          if (sram_write_req.wdata !== ed || sram_write_req.xbar !== ex || sram_write_req_latched !== 1'b1) begin
            errors++;
            $display("FAIL req: got wdata %0h xbar %0h latched %0b expected wdata %0h xbar %0h latched 1",
                     sram_write_req.wdata, sram_write_req.xbar, sram_write_req_latched, ed, ex);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_row(input logic [ROW_BITS-1:0] d, input xbar_desc_t x);
    exp_data_q.push_back(d);
    exp_xbar_q.push_back(x);
  endtask

  function automatic logic [ROW_BITS-1:0] put(input logic [ROW_BITS-1:0] r, input int k, input logic [63:0] d);
    logic [ROW_BITS-1:0] t;
    t = r;
    t[k*BEAT_BITS +: BEAT_BITS] = d;
    return t;
  endfunction

  task automatic do_alloc(input logic [7:0] id, input xbar_desc_t x, input logic [3:0] nb);
    alloc_id        = id;
    alloc_xbar      = x;
    alloc_num_beats = nb;
    alloc_valid     = 1'b1;
    #1;
    chk("alloc_ready_on_alloc", ROW_BITS'(alloc_ready), ROW_BITS'(1'b1));
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] id, input logic [63:0] d);
    beat_valid = 1'b1;
    beat_id    = id;
    beat_data  = d;
    tick();
    beat_valid = 1'b0;
  endtask

  task automatic probe_ready(input string name, input logic [7:0] id, input logic exp);
    alloc_id = id;
    #1;
    chk(name, ROW_BITS'(alloc_ready), ROW_BITS'(exp));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_data_q.size() != 0 || sram_write_req.valid) && n < 60) begin
      tick();
      n++;
    end
    chk("drain_timeout", ROW_BITS'(n < 60), ROW_BITS'(1'b1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ROW_BITS-1:0] r, r52;
    xbar_desc_t x1, x2, x3, x4, x5;
    int h0;

    fork
      monitor();
    join_none

    x1 = xbar_desc_t'(24'h0F01FF);
    x2 = xbar_desc_t'(24'hA5_02_3C);
    x3 = xbar_desc_t'(24'h5A_07_C3);
    x4 = xbar_desc_t'(24'h12_34_56);
    x5 = xbar_desc_t'(24'hFE_DC_BA);

    rst = 1'b1;
    tick(); tick();
    chk("rst_valid", ROW_BITS'(sram_write_req.valid), '0);
    chk("rst_wdata", sram_write_req.wdata, '0);
    chk("rst_latched", ROW_BITS'(sram_write_req_latched), '0);
    chk("rst_busy", ROW_BITS'(busy), '0);
    chk("rst_err", ROW_BITS'(err), '0);
    rst = 1'b0;
    tick();
    chk("idle_ready", ROW_BITS'(alloc_ready), ROW_BITS'(1'b1));

    // Single 8-beat row, beats on consecutive cycles.
    r = '0;
    for (int k = 0; k < 8; k++) r = put(r, k, 64'(k));
    expect_row(r, x1);
    do_alloc(8'h11, x1, 4'd8);
    for (int k = 0; k < 8; k++) send_beat(8'h11, 64'(k));
    chk("s1_valid_at_last_plus1", ROW_BITS'(sram_write_req.valid), ROW_BITS'(1'b1));
    chk("s1_latched_at_last_plus1", ROW_BITS'(sram_write_req_latched), ROW_BITS'(1'b1));
    tick();
    chk("s1_latched_one_cycle", ROW_BITS'(sram_write_req_latched), '0);
    chk("s1_busy_after", ROW_BITS'(busy), '0);

    // Interleaved IDs: 0x22 completes first.
    do_alloc(8'h11, x2, 4'd4);
    do_alloc(8'h22, x3, 4'd2);
    r = '0;
    r = put(r, 0, 64'h2200); r = put(r, 1, 64'h2201);
    expect_row(r, x3);
    r = '0;
    for (int k = 0; k < 4; k++) r = put(r, k, 64'h1100 + 64'(k));
    expect_row(r, x2);
    send_beat(8'h11, 64'h1100);
    send_beat(8'h22, 64'h2200);
    send_beat(8'h11, 64'h1101);
    send_beat(8'h22, 64'h2201);
    send_beat(8'h11, 64'h1102);
    send_beat(8'h11, 64'h1103);
    wait_drain();

    // Short row leaves upper beats zero; zero-beat row is all zero next cycle.
    r = '0;
    r = put(r, 0, 64'hAA00); r = put(r, 1, 64'hAA01); r = put(r, 2, 64'hAA02);
    expect_row(r, x4);
    do_alloc(8'h33, x4, 4'd3);
    send_beat(8'h33, 64'hAA00);
    send_beat(8'h33, 64'hAA01);
    send_beat(8'h33, 64'hAA02);
    wait_drain();
    expect_row('0, x5);
    do_alloc(8'h44, x5, 4'd0);
    chk("zero_beat_valid_next", ROW_BITS'(sram_write_req.valid), ROW_BITS'(1'b1));
    wait_drain();

    // Three rows completed under stall, released after 10 cycles.
    be_stall = 1'b1;
    do_alloc(8'h51, x1, 4'd1);
    do_alloc(8'h52, x2, 4'd1);
    do_alloc(8'h53, x3, 4'd2);
    r52 = put('0, 0, 64'h5200);
    expect_row(r52, x2);
    expect_row(put('0, 0, 64'h5100), x1);
    expect_row(put(put('0, 0, 64'h5300), 1, 64'h5301), x3);
    send_beat(8'h52, 64'h5200);
    send_beat(8'h51, 64'h5100);
    send_beat(8'h53, 64'h5300);
    send_beat(8'h53, 64'h5301);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("stall_valid", ROW_BITS'(sram_write_req.valid), ROW_BITS'(1'b1));
      chk("stall_wdata", sram_write_req.wdata, r52);
      chk("stall_latched", ROW_BITS'(sram_write_req_latched), '0);
    end
    h0 = handoffs;
    be_stall = 1'b0;
    tick(); tick(); tick();
    chk("release_3_handoffs", ROW_BITS'(handoffs - h0), ROW_BITS'(3));
    chk("release_then_idle", ROW_BITS'(sram_write_req.valid), '0);

    // Slot exhaustion, duplicate IDs, and a slot freed by a handoff.
    be_stall = 1'b1;
    do_alloc(8'h61, x1, 4'd1);
    do_alloc(8'h62, x2, 4'd1);
    do_alloc(8'h63, x3, 4'd1);
    do_alloc(8'h64, x4, 4'd1);
    probe_ready("full_ready", 8'h65, 1'b0);
    expect_row(put('0, 0, 64'h61), x1);
    send_beat(8'h61, 64'h61);
    probe_ready("one_free_ready", 8'h65, 1'b1);
    probe_ready("dup_ready", 8'h62, 1'b0);
    expect_row(put('0, 0, 64'h62), x2);
    expect_row(put('0, 0, 64'h63), x3);
    expect_row(put('0, 0, 64'h64), x4);
    send_beat(8'h62, 64'h62);
    send_beat(8'h63, 64'h63);
    send_beat(8'h64, 64'h64);
    do_alloc(8'h70, x5, 4'd1);
    probe_ready("refull_ready", 8'h71, 1'b0);
    be_stall = 1'b0;
    probe_ready("pre_handoff_ready", 8'h71, 1'b0);
    tick();
    probe_ready("post_handoff_ready", 8'h71, 1'b1);
    expect_row(put('0, 0, 64'h70), x5);
    send_beat(8'h70, 64'h70);
    wait_drain();

    // Unallocated beat is dropped.
`ifdef SRAM_WRITE_ASSEMBLER_ERR_EN
    chk("err_before", ROW_BITS'(err), '0);
    send_beat(8'h55, 64'hDEAD);
    chk("err_set", ROW_BITS'(err), ROW_BITS'(1'b1));
    tick(); tick(); tick();
    chk("err_sticky", ROW_BITS'(err), ROW_BITS'(1'b1));
`else
    send_beat(8'h55, 64'hDEAD);
    chk("err_tied_low", ROW_BITS'(err), '0);
`endif
    chk("drop_no_req", ROW_BITS'(sram_write_req.valid), '0);
    chk("drop_not_busy", ROW_BITS'(busy), '0);

    // Reset in the middle of a fill.
    do_alloc(8'h77, x1, 4'd4);
    send_beat(8'h77, 64'h7700);
    send_beat(8'h77, 64'h7701);
    chk("midfill_busy", ROW_BITS'(busy), ROW_BITS'(1'b1));
    rst = 1'b1;
    tick();
    chk("midrst_valid", ROW_BITS'(sram_write_req.valid), '0);
    chk("midrst_latched", ROW_BITS'(sram_write_req_latched), '0);
    chk("midrst_busy", ROW_BITS'(busy), '0);
    chk("midrst_err", ROW_BITS'(err), '0);
    rst = 1'b0;
    probe_ready("midrst_ready", 8'h77, 1'b1);
    send_beat(8'h77, 64'h7702);
    send_beat(8'h77, 64'h7703);
    chk("postrst_drop_valid", ROW_BITS'(sram_write_req.valid), '0);
    chk("postrst_drop_busy", ROW_BITS'(busy), '0);

    // Beat count above the row size is clamped to a full row.
    r = '0;
    for (int k = 0; k < 8; k++) r = put(r, k, 64'h8800 + 64'(k));
    expect_row(r, x2);
    do_alloc(8'h88, x2, 4'd12);
    for (int k = 0; k < 8; k++) begin
      chk("clamp_no_early_req", ROW_BITS'(sram_write_req.valid), '0);
      send_beat(8'h88, 64'h8800 + 64'(k));
    end
    chk("clamp_valid", ROW_BITS'(sram_write_req.valid), ROW_BITS'(1'b1));
    wait_drain();

    // Re-using the reset ID carries none of the pre-reset beats.
    expect_row(put(put('0, 0, 64'hE0), 1, 64'hE1), x3);
    do_alloc(8'h77, x3, 4'd2);
    send_beat(8'h77, 64'hE0);
    send_beat(8'h77, 64'hE1);
    wait_drain();

    chk("scoreboard_empty", ROW_BITS'(exp_data_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
